// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the BCD-to-binary converter and the binary-to-BCD display path.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_CONV  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned   BCD_W         = 4;
  localparam logic [3:0]    BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Start/busy/done handshake bundle between the requester and the BCD-to-binary converter.
interface bcd_to_bin_seq_if
  import bcd_pkg::*;
#(
  parameter int unsigned N      = 10,
  parameter int unsigned DIGITS = 4
);

  logic                      start;
  logic [BCD_W*DIGITS-1:0]   bcd_in;
  logic [N-1:0]              bin_out;
  logic                      busy;
  logic                      done;
  logic                      err;
  logic                      ovf;

  modport master (output start, bcd_in, input bin_out, busy, done, err, ovf);
  modport slave  (input start, bcd_in, output bin_out, busy, done, err, ovf);

endinterface

// File: rtl/bcd_digit_check.sv
// Flags any packed BCD digit outside 0..9.
module bcd_digit_check
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic [BCD_W*DIGITS-1:0] bcd,
  output logic                    any_invalid
);

  always_comb begin
    any_invalid = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (bcd[k*BCD_W +: BCD_W] > BCD_MAX_DIGIT) any_invalid = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter: one x10 accumulate per cycle, MSD first,
// saturating at 2^N-1, with start/busy/done handshake.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int unsigned N      = 10,
  parameter int unsigned DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  bcd_to_bin_seq_if.slave  bus
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t                  state;
  logic [BCD_W*DIGITS-1:0] op_r;
  logic [N-1:0]            acc;
  logic [IDX_W-1:0]        idx;
  logic                    err_r;
  logic                    ovf_r;
  logic                    any_invalid;
  logic [BCD_W-1:0]        digit;
  logic [N+3:0]            acc_x;
  logic [N+3:0]            nxt;
  logic                    sat;

  bcd_digit_check #(.DIGITS(DIGITS)) u_check (
    .bcd         (op_r),
    .any_invalid (any_invalid)
  );

  // acc*10 as shift-add so no multiplier is inferred
  always_comb begin
    digit = op_r[idx*BCD_W +: BCD_W];
    acc_x = {4'b0000, acc};
    nxt   = (acc_x << 3) + (acc_x << 1) + {{N{1'b0}}, digit};
    sat   = ovf_r || (nxt[N+3:N] != 4'b0000);
  end

  // Outputs are loaded on the transition into DONE so done/result/flags are
  // registered yet visible during the DONE cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_r        <= '0;
      acc         <= '0;
      idx         <= '0;
      err_r       <= 1'b0;
      ovf_r       <= 1'b0;
      bus.bin_out <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
      bus.ovf     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            op_r     <= bus.bcd_in;
            err_r    <= 1'b0;
            ovf_r    <= 1'b0;
            bus.busy <= 1'b1;
            state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (any_invalid) begin
            err_r       <= 1'b1;
            bus.done    <= 1'b1;
            bus.bin_out <= '0;
            bus.err     <= 1'b1;
            bus.ovf     <= 1'b0;
            state       <= ST_DONE;
          end else begin
            acc   <= '0;
            idx   <= IDX_W'(DIGITS - 1);
            ovf_r <= 1'b0;
            state <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (sat) begin
            ovf_r <= 1'b1;
            acc   <= '1;
          end else begin
            acc   <= nxt[N-1:0];
          end
          if (idx == '0) begin
            bus.done    <= 1'b1;
            bus.bin_out <= sat ? '1 : nxt[N-1:0];
            bus.err     <= 1'b0;
            bus.ovf     <= sat;
            state       <= ST_DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        ST_DONE: begin
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench: cycle-level behavioural model of two converter instances
// (N=10 and N=14) compared every cycle, plus directed literal expectations.
module tb_bcd_to_bin_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_to_bin_seq_if #(.N(10), .DIGITS(4)) i10 ();
  bcd_to_bin_seq_if #(.N(14), .DIGITS(4)) i14 ();

  bcd_to_bin_seq #(.N(10), .DIGITS(4)) u10 (.clk(clk), .rst(rst), .bus(i10.slave));
  bcd_to_bin_seq #(.N(14), .DIGITS(4)) u14 (.clk(clk), .rst(rst), .bus(i14.slave));

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference conversion from decimal digit values: {err, ovf, result}
  function automatic logic [33:0] ref_conv(input logic [15:0] b, input int n);
    int unsigned v;
    int unsigned d;
    int unsigned maxv;
    logic e;
    logic [15:0] bb;
    bb = b;
    v = 0;
    e = 1'b0;
    maxv = (1 << n) - 1;
    for (int k = 3; k >= 0; k--) begin
      d = int'(bb[4*k +: 4]);
      if (d > 9) e = 1'b1;
      v = v * 10 + d;
    end
    if (e) return {1'b1, 1'b0, 32'd0};
    if (v > maxv) return {1'b0, 1'b1, maxv};
    return {1'b0, 1'b0, v};
  endfunction

  // Model: busy from accept to the done cycle, done exactly lat cycles after accept.
  bit          m_act [2];
  int          m_k   [2];
  int          m_lat [2];
  logic [33:0] m_pend[2];
  logic [31:0] m_res [2];
  bit          m_err [2];
  bit          m_ovf [2];
  bit          m_done[2];

  task automatic mstep(input int i, input logic s, input logic [15:0] b, input int n);
    if (rst) begin
      m_act[i] = 0; m_k[i] = 0; m_done[i] = 0;
      m_res[i] = 0; m_err[i] = 0; m_ovf[i] = 0;
    end else begin
      m_done[i] = 0;
      if (m_act[i]) begin
        if (m_k[i] == m_lat[i]) m_act[i] = 0;
        else begin
          m_k[i]++;
          if (m_k[i] == m_lat[i]) begin
            m_done[i] = 1;
            m_err[i]  = m_pend[i][33];
            m_ovf[i]  = m_pend[i][32];
            m_res[i]  = m_pend[i][31:0];
          end
        end
      end else if (s) begin
        m_act[i]  = 1;
        m_k[i]    = 1;
        m_pend[i] = ref_conv(b, n);
        m_lat[i]  = m_pend[i][33] ? 2 : 6;
      end
    end
  endtask

  always @(posedge clk) begin
    mstep(0, i10.start, i10.bcd_in, 10);
    mstep(1, i14.start, i14.bcd_in, 14);
  end

  always @(negedge clk) begin
    if (checking) begin
      cmp("n10.busy",    32'(i10.busy),    32'(m_act[0]));
      cmp("n10.done",    32'(i10.done),    32'(m_done[0]));
      cmp("n10.bin_out", 32'(i10.bin_out), m_res[0]);
      cmp("n10.err",     32'(i10.err),     32'(m_err[0]));
      cmp("n10.ovf",     32'(i10.ovf),     32'(m_ovf[0]));
      cmp("n14.busy",    32'(i14.busy),    32'(m_act[1]));
      cmp("n14.done",    32'(i14.done),    32'(m_done[1]));
      cmp("n14.bin_out", 32'(i14.bin_out), m_res[1]);
      cmp("n14.err",     32'(i14.err),     32'(m_err[1]));
      cmp("n14.ovf",     32'(i14.ovf),     32'(m_ovf[1]));
    end
  end

  function automatic logic get_done(input int i);
    return (i == 0) ? i10.done : i14.done;
  endfunction

  // Pulse start for one cycle, scramble bcd_in afterwards, wait for done and check latency.
  task automatic go(input int i, input logic [15:0] b, input int lat_exp);
    int k;
    bit seen;
    @(negedge clk);
    if (i == 0) begin i10.start = 1'b1; i10.bcd_in = b; end
    else        begin i14.start = 1'b1; i14.bcd_in = b; end
    @(negedge clk);
    if (i == 0) begin i10.start = 1'b0; i10.bcd_in = 16'($urandom); end
    else        begin i14.start = 1'b0; i14.bcd_in = 16'($urandom); end
    k = 1;
    seen = 0;
    while (!seen && k <= 20) begin
      if (get_done(i)) seen = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    if (!seen) cmp("done_timeout", 32'd0, 32'd1);
    else       cmp("latency", 32'(k), 32'(lat_exp));
  endtask

  initial begin
    int ndone;
    logic [15:0] v;
    int unsigned dec;

    i10.start = 1'b0; i10.bcd_in = '0;
    i14.start = 1'b0; i14.bcd_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;
    @(negedge clk);
    cmp("reset.bin_out", 32'(i10.bin_out), 32'd0);
    cmp("reset.busy",    32'(i10.busy),    32'd0);
    cmp("reset.done",    32'(i10.done),    32'd0);

    // 1: basic conversion
    go(0, 16'h0512, 6);
    cmp("t1.bin_out", 32'(i10.bin_out), 32'd512);
    cmp("t1.err",     32'(i10.err),     32'd0);
    cmp("t1.ovf",     32'(i10.ovf),     32'd0);

    // 2: saturation boundary
    go(0, 16'h1023, 6);
    cmp("t2a.bin_out", 32'(i10.bin_out), 32'd1023);
    cmp("t2a.ovf",     32'(i10.ovf),     32'd0);
    go(0, 16'h1024, 6);
    cmp("t2b.bin_out", 32'(i10.bin_out), 32'h3FF);
    cmp("t2b.ovf",     32'(i10.ovf),     32'd1);
    go(0, 16'h9999, 6);
    cmp("t2c.bin_out", 32'(i10.bin_out), 32'h3FF);
    cmp("t2c.ovf",     32'(i10.ovf),     32'd1);

    // 3: digit error, then clean conversion clears flags
    go(0, 16'h09A1, 2);
    cmp("t3a.err",     32'(i10.err),     32'd1);
    cmp("t3a.bin_out", 32'(i10.bin_out), 32'd0);
    cmp("t3a.ovf",     32'(i10.ovf),     32'd0);
    go(0, 16'h0000, 6);
    cmp("t3b.bin_out", 32'(i10.bin_out), 32'd0);
    cmp("t3b.err",     32'(i10.err),     32'd0);

    // 4: start held high, bcd_in toggling every cycle
    ndone = 0;
    for (int k = 0; k < 28; k++) begin
      @(negedge clk);
      if (i10.done) ndone++;
      i10.start  = 1'b1;
      i10.bcd_in = (k % 2 == 0) ? 16'h0123 : 16'h0456;
    end
    @(negedge clk);
    i10.start = 1'b0;
    cmp("t4.done_count", 32'(ndone), 32'd4);
    repeat (8) @(negedge clk);

    // 5: reset during second CONV cycle aborts
    @(negedge clk);
    i10.start = 1'b1; i10.bcd_in = 16'h0777;
    @(negedge clk);
    i10.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("t5.busy",    32'(i10.busy),    32'd0);
    cmp("t5.done",    32'(i10.done),    32'd0);
    cmp("t5.bin_out", 32'(i10.bin_out), 32'd0);
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (i10.done) ndone++;
    end
    cmp("t5.no_done", 32'(ndone), 32'd0);
    go(0, 16'h0042, 6);
    cmp("t5.bin_out_42", 32'(i10.bin_out), 32'd42);

    // 6: valid BCD sweep on N=14
    go(1, 16'h9999, 6);
    cmp("t6.max", 32'(i14.bin_out), 32'd9999);
    cmp("t6.max_ovf", 32'(i14.ovf), 32'd0);
    go(1, 16'h0000, 6);
    cmp("t6.zero", 32'(i14.bin_out), 32'd0);
    for (int n = 0; n < 300; n++) begin
      dec = $urandom_range(0, 9999);
      v = {4'(dec / 1000), 4'((dec / 100) % 10), 4'((dec / 10) % 10), 4'(dec % 10)};
      go(1, v, 6);
      cmp("t6.sweep", 32'(i14.bin_out), dec);
      cmp("t6.sweep_flags", {30'd0, i14.err, i14.ovf}, 32'd0);
    end

    repeat (3) @(negedge clk);
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
